div_update_ctrl: RTL and testbench

Sequencing controller for the PWM timer's clock divider. It accepts divisor write requests from the Wishbone register file into a shadow register and commits them to the divider only at a safe point: a period boundary, bypass mode, or, optionally, a timeout. On commit it drives the divider's local reset, so the divided clock never emits a truncated or glitched period. It sits between the register file and the divider, in the Wishbone clock domain.

---
 rtl/pwm_timer_pkg.sv | 20 ++
 rtl/div_upd_timeout.sv | 28 ++
 rtl/div_update_ctrl.sv | 153 +++++++++++++++
 tb/tb_div_update_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_timer_pkg.sv
// Shared types and widths for the PWM timer clock-divider update path.
package pwm_timer_pkg;

    localparam int unsigned DIV_W    = 16;
    localparam int unsigned SETTLE_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PENDING = 3'd1,
        ST_APPLY   = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_DONE    = 3'd4
    } upd_state_e;

    // Divisors 0 and 1 both mean the divider is bypassed.
    function automatic logic is_bypass(input logic [DIV_W-1:0] div);
        return ~|div[DIV_W-1:1];
    endfunction

endpackage

// File: rtl/div_upd_timeout.sv
// PENDING timeout: down-counter reloaded on clear, terminal flag at zero while enabled.
module div_upd_timeout
    import pwm_timer_pkg::*;
#(
    parameter logic [DIV_W-1:0] TIMEOUT_CYC = 16'hFFFF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [DIV_W-1:0] LOAD = TIMEOUT_CYC - 16'd1;

    logic [DIV_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= LOAD;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 16'd1;
        end
    end

    assign tc_o = en_i & (cnt_q == '0);

endmodule

// File: rtl/div_update_ctrl.sv
// Commits divisor writes to the PWM clock divider only at safe points and resets it on commit.
// Define DIV_UPDATE_TIMEOUT_EN to force a commit after TIMEOUT_CYC cycles in PENDING.
//
// state   | meaning
// IDLE    | no update outstanding, writes accepted
// PENDING | shadow holds a new divisor, waiting for a period boundary
// APPLY   | divisor updated, divider held in reset
// SETTLE  | divider reset held for SETTLE_CYC cycles
// DONE    | reset released, completion pulse
module div_update_ctrl
    import pwm_timer_pkg::*;
#(
    parameter logic [DIV_W-1:0] RESET_DIV   = 16'd1,
    parameter int unsigned      SETTLE_CYC  = 2,
    parameter logic [DIV_W-1:0] TIMEOUT_CYC = 16'hFFFF
) (
    input  logic             i_wb_clk,
    input  logic             i_wb_rst,
    input  logic             i_wr_req,
    input  logic [DIV_W-1:0] i_wr_div,
    input  logic             i_period_end,
    output logic             o_wr_ack,
    output logic [DIV_W-1:0] o_divisor,
    output logic             o_div_rst,
    output logic             o_busy,
    output logic             o_upd_done,
    output logic             o_timeout
);

    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYC - 1);

    if (SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_bad_settle
        $error("div_update_ctrl: SETTLE_CYC must be within 1..15");
    end
    if (TIMEOUT_CYC == '0) begin : g_bad_timeout
        $error("div_update_ctrl: TIMEOUT_CYC must be at least 1");
    end

    upd_state_e          state_q;
    logic [DIV_W-1:0]    shadow_q;
    logic [DIV_W-1:0]    divisor_q;
    logic [SETTLE_W-1:0] settle_cnt_q;
    logic                div_rst_q;
    logic                wr_ack_q;
    logic                busy_q;
    logic                upd_done_q;
    logic                timeout_q;

    logic wr_accept;
    logic wr_same;
    logic tmo_tc;

    // The ack cycle is masked so a requester that drops one edge late is not accepted twice.
    assign wr_accept = i_wr_req & ~wr_ack_q &
                       ((state_q == ST_IDLE) || (state_q == ST_PENDING));
    assign wr_same   = (i_wr_div == divisor_q);

`ifdef DIV_UPDATE_TIMEOUT_EN
    div_upd_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk_i (i_wb_clk),
        .rst_i (i_wb_rst),
        .clr_i (wr_accept),
        .en_i  (state_q == ST_PENDING),
        .tc_o  (tmo_tc)
    );
`else
    assign tmo_tc = 1'b0;
`endif

    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            state_q      <= ST_IDLE;
            shadow_q     <= RESET_DIV;
            divisor_q    <= RESET_DIV;
            settle_cnt_q <= '0;
            div_rst_q    <= 1'b1;
            wr_ack_q     <= 1'b0;
            busy_q       <= 1'b0;
            upd_done_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            wr_ack_q   <= 1'b0;
            upd_done_q <= 1'b0;
            timeout_q  <= 1'b0;

            if (wr_accept) begin
                shadow_q <= i_wr_div;
                wr_ack_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    div_rst_q <= 1'b0;
                    busy_q    <= 1'b0;
                    if (wr_accept && !wr_same) begin
                        busy_q <= 1'b1;
                        // A bypassed divider has no period boundary to wait for.
                        if (is_bypass(i_wr_div) || is_bypass(divisor_q)) begin
                            state_q   <= ST_APPLY;
                            divisor_q <= i_wr_div;
                            div_rst_q <= 1'b1;
                        end else begin
                            state_q <= ST_PENDING;
                        end
                    end
                end
                ST_PENDING: begin
                    if (wr_accept) begin
                        if (wr_same) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else if (i_period_end || tmo_tc) begin
                        state_q   <= ST_APPLY;
                        divisor_q <= shadow_q;
                        div_rst_q <= 1'b1;
                        timeout_q <= ~i_period_end;
                    end
                end
                ST_APPLY: begin
                    state_q      <= ST_SETTLE;
                    settle_cnt_q <= SETTLE_LOAD;
                end
                ST_SETTLE: begin
                    if (settle_cnt_q == '0) begin
                        state_q    <= ST_DONE;
                        div_rst_q  <= 1'b0;
                        upd_done_q <= 1'b1;
                    end else begin
                        settle_cnt_q <= settle_cnt_q - 4'd1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_wr_ack   = wr_ack_q;
    assign o_divisor  = divisor_q;
    assign o_div_rst  = div_rst_q;
    assign o_busy     = busy_q;
    assign o_upd_done = upd_done_q;
    assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_div_update_ctrl.sv
// Directed bench for div_update_ctrl (RESET_DIV=1, SETTLE_CYC=2, TIMEOUT_CYC=10).
module tb_div_update_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_req;
    logic [15:0] wr_div;
    logic        period_end;
    logic        wr_ack;
    logic [15:0] divisor;
    logic        div_rst;
    logic        busy;
    logic        upd_done;
    logic        timeout;

    int n_cmp = 0;
    int n_err = 0;
    logic saw6 = 1'b0;

    always #5 clk = ~clk;

    div_update_ctrl #(
        .RESET_DIV   (16'd1),
        .SETTLE_CYC  (2),
        .TIMEOUT_CYC (16'd10)
    ) dut (
        .i_wb_clk     (clk),
        .i_wb_rst     (rst),
        .i_wr_req     (wr_req),
        .i_wr_div     (wr_div),
        .i_period_end (period_end),
        .o_wr_ack     (wr_ack),
        .o_divisor    (divisor),
        .o_div_rst    (div_rst),
        .o_busy       (busy),
        .o_upd_done   (upd_done),
        .o_timeout    (timeout)
    );

    always @(posedge clk) if (divisor == 16'd6) saw6 <= 1'b1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // From the APPLY cycle: two SETTLE cycles, then DONE, then IDLE.
    task automatic finish_commit(input string tag);
        tick();
        check({tag, "_settle1_rst"}, div_rst, 1);
        tick();
        check({tag, "_settle2_rst"}, div_rst, 1);
        check({tag, "_settle2_done"}, upd_done, 0);
        tick();
        check({tag, "_done_pulse"}, upd_done, 1);
        check({tag, "_done_rst"}, div_rst, 0);
        check({tag, "_done_busy"}, busy, 1);
        tick();
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_idle_done"}, upd_done, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wr_req = 1'b0; wr_div = 16'd0; period_end = 1'b0;
        tick();
        tick();
        check("rst_divisor", divisor, 1);
        check("rst_div_rst", div_rst, 1);
        check("rst_busy", busy, 0);
        check("rst_ack", wr_ack, 0);
        check("rst_done", upd_done, 0);
        check("rst_timeout", timeout, 0);
        rst = 1'b0;
        tick();
        check("post_rst_div_rst", div_rst, 0);
        check("post_rst_divisor", divisor, 1);

        // Bypass write: ack and APPLY together one cycle after acceptance.
        wr_req = 1'b1; wr_div = 16'd4;
        tick();
        wr_req = 1'b0;
        check("byp_ack", wr_ack, 1);
        check("byp_divisor", divisor, 4);
        check("byp_apply_rst", div_rst, 1);
        check("byp_busy", busy, 1);
        finish_commit("byp");
        check("byp_final_div", divisor, 4);

        // Last write wins; period_end coinciding with the second write is ignored.
        wr_req = 1'b1; wr_div = 16'd6;
        tick();
        wr_req = 1'b0;
        check("pend_ack6", wr_ack, 1);
        check("pend_busy", busy, 1);
        check("pend_div_held", divisor, 4);
        check("pend_no_rst", div_rst, 0);
        tick();
        check("pend_ack_pulse", wr_ack, 0);
        wr_req = 1'b1; wr_div = 16'd8; period_end = 1'b1;
        tick();
        wr_req = 1'b0; period_end = 1'b0;
        check("pend_ack8", wr_ack, 1);
        check("pend_pe_ignored", divisor, 4);
        check("pend_pe_ignored_rst", div_rst, 0);
        tick();
        period_end = 1'b1;
        tick();
        period_end = 1'b0;
        check("pend_apply_div", divisor, 8);
        check("pend_apply_rst", div_rst, 1);
        check("pend_apply_tmo", timeout, 0);
        finish_commit("pend");
        check("never_saw_6", saw6, 0);

        // Rewrite of the active divisor from IDLE.
        wr_req = 1'b1; wr_div = 16'd8;
        tick();
        wr_req = 1'b0;
        check("same_ack", wr_ack, 1);
        check("same_busy", busy, 0);
        check("same_rst", div_rst, 0);
        tick();
        check("same_busy2", busy, 0);

        // PENDING cancelled by a write equal to the active divisor.
        wr_req = 1'b1; wr_div = 16'd12;
        tick();
        wr_req = 1'b0;
        check("cancel_busy", busy, 1);
        tick();
        wr_req = 1'b1; wr_div = 16'd8;
        tick();
        wr_req = 1'b0;
        check("cancel_ack", wr_ack, 1);
        check("cancel_busy_off", busy, 0);
        period_end = 1'b1;
        tick();
        period_end = 1'b0;
        check("cancel_no_apply", divisor, 8);
        check("cancel_no_rst", div_rst, 0);

        // Request held through SETTLE/DONE is only acked back in IDLE.
        wr_req = 1'b1; wr_div = 16'd1;
        tick();
        wr_req = 1'b0;
        check("hold_apply_div", divisor, 1);
        tick();
        wr_req = 1'b1; wr_div = 16'd3;
        tick();
        check("hold_settle_noack", wr_ack, 0);
        tick();
        check("hold_done_noack", wr_ack, 0);
        check("hold_done_pulse", upd_done, 1);
        tick();
        check("hold_idle_noack", wr_ack, 0);
        tick();
        wr_req = 1'b0;
        check("hold_ack", wr_ack, 1);
        check("hold_apply_div3", divisor, 3);
        check("hold_apply_rst", div_rst, 1);
        finish_commit("hold");

`ifdef DIV_UPDATE_TIMEOUT_EN
        // Forced commit 10 cycles after entering PENDING.
        wr_req = 1'b1; wr_div = 16'd5;
        tick();
        wr_req = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check("tmo_pre_div", divisor, 3);
        check("tmo_pre_flag", timeout, 0);
        tick();
        check("tmo_apply_div", divisor, 5);
        check("tmo_flag", timeout, 1);
        check("tmo_apply_rst", div_rst, 1);
        tick();
        check("tmo_flag_pulse", timeout, 0);
        tick();
        tick();
        check("tmo_done", upd_done, 1);
        tick();

        // period_end at the terminal count takes the normal path.
        wr_req = 1'b1; wr_div = 16'd7;
        tick();
        wr_req = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        period_end = 1'b1;
        tick();
        period_end = 1'b0;
        check("tc_pe_div", divisor, 7);
        check("tc_pe_flag", timeout, 0);
        finish_commit("tc_pe");
`else
        // Without the timeout PENDING waits for period_end indefinitely.
        wr_req = 1'b1; wr_div = 16'd5;
        tick();
        wr_req = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("wait_div", divisor, 3);
        check("wait_busy", busy, 1);
        check("wait_flag", timeout, 0);
        period_end = 1'b1;
        tick();
        period_end = 1'b0;
        check("wait_apply_div", divisor, 5);
        check("wait_apply_flag", timeout, 0);
        finish_commit("wait");
`endif

        // Reset during SETTLE discards the update in flight.
        wr_req = 1'b1; wr_div = 16'd9;
        tick();
        wr_req = 1'b0;
        period_end = 1'b1;
        tick();
        period_end = 1'b0;
        check("mid_apply_div", divisor, 9);
        tick();
        rst = 1'b1;
        tick();
        check("mid_rst_div", divisor, 1);
        check("mid_rst_div_rst", div_rst, 1);
        check("mid_rst_busy", busy, 0);
        rst = 1'b0;
        tick();
        check("mid_post_div_rst", div_rst, 0);
        check("mid_post_busy", busy, 0);
        check("mid_post_done", upd_done, 0);
        check("mid_post_div", divisor, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
